// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - LSB-first serial-to-parallel deserializer with valid/ready output (optional parity: S2P_PARITY_EN)
`timescale 1ns/1ps

module serial_to_parallel #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sclr,
    input  logic                  din,
    input  logic                  din_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   shreg_next;
    logic [DATA_WIDTH-1:0]   shift_word;
    logic [DATA_WIDTH-1:0]   word;
    logic                    complete;
    logic                    load;
    logic                    drop;
`ifdef S2P_PARITY_EN
    logic                    word_perr;
`endif

    // New bits enter at the top so the first received bit ends up in bit 0.
    assign shift_word = {din, shreg[DATA_WIDTH-1:1]};

    // A finished word is taken if the holding register is empty or being drained this cycle.
    assign load = complete && (!dout_valid || dout_ready);
    assign drop = complete && dout_valid && !dout_ready;

    // Framing state, bit counter and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= COLLECT;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
        end
    end

    // Next framing state; sclr wins over a bit presented in the same cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        complete   = 1'b0;
        word       = shift_word;
`ifdef S2P_PARITY_EN
        word_perr  = 1'b0;
`endif
        if (sclr) begin
            state_next = COLLECT;
            cnt_next   = '0;
            shreg_next = '0;
        end else if (din_en) begin
            case (state)
                COLLECT: begin
                    shreg_next = shift_word;
                    if (cnt == LAST_BIT) begin
                        cnt_next = '0;
`ifdef S2P_PARITY_EN
                        // Hold the assembled word in shreg until the parity bit arrives.
                        state_next = PARITY;
`else
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                PARITY: begin
`ifdef S2P_PARITY_EN
                    // Even parity: the data bits plus the parity bit must XOR to zero.
                    complete   = 1'b1;
                    word       = shreg;
                    word_perr  = (^shreg) ^ din;
`endif
                    state_next = COLLECT;
                end
                default: begin
                    state_next = COLLECT;
                end
            endcase
        end
    end

    // Output holding register, handshake and overrun pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            if (load) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef S2P_PARITY_EN
    // Parity status travels with the word on dout and clears when that word is consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= word_perr;
        end else if (dout_valid && dout_ready) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
